// File: rtl/mem_operand_fetch.sv
// mem_operand_fetch
//   Operand-fetch stage ahead of write-back. Accepts one instruction, reads
//   up to two memory source operands from the data cache (strictly one after
//   the other), then holds the finished operand bundle until write-back takes it.
// Ports
//   clk, reset                     : clock, asynchronous active-high reset
//   inValid/inReady                : upstream instruction handshake
//   inRip, inOp1/2, inSide         : instruction pointer, register operands, sideband
//   inSrc1IsMem/inSrc2IsMem        : operand n comes from memory
//   inAddrSrc1/inAddrSrc2          : operand byte addresses
//   killIn                         : flush the current instruction
//   outValid/outReady              : write-back handshake
//   outRip, outOp1/2, outSide      : captured bundle
//   dcReqcyc/dcReq/dcReqtag/dcReqack        : cache read request
//   dcRespcyc/dcResp/dcResptag/dcRespack    : cache read response
module mem_operand_fetch #(
   parameter int unsigned SIDE_W = 128,
   parameter int unsigned TAG_W  = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inValid,
   output logic              inReady,
   input  logic [63:0]       inRip,
   input  logic              inSrc1IsMem,
   input  logic              inSrc2IsMem,
   input  logic [63:0]       inAddrSrc1,
   input  logic [63:0]       inAddrSrc2,
   input  logic [63:0]       inOp1,
   input  logic [63:0]       inOp2,
   input  logic [SIDE_W-1:0] inSide,
   input  logic              killIn,
   output logic              outValid,
   input  logic              outReady,
   output logic [63:0]       outRip,
   output logic [63:0]       outOp1,
   output logic [63:0]       outOp2,
   output logic [SIDE_W-1:0] outSide,
   output logic              dcReqcyc,
   output logic [63:0]       dcReq,
   output logic [TAG_W-1:0]  dcReqtag,
   input  logic              dcReqack,
   input  logic              dcRespcyc,
   input  logic [63:0]       dcResp,
   input  logic [TAG_W-1:0]  dcResptag,
   output logic              dcRespack
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_HOLD
   } state_t;

   // Read request tag: {read, memory/data space, reserved, operand index}
   localparam logic [TAG_W-1:0] TAG_SRC1 = TAG_W'({1'b1, 4'b0001, 7'b0, 1'b0});
   localparam logic [TAG_W-1:0] TAG_SRC2 = TAG_W'({1'b1, 4'b0001, 7'b0, 1'b1});

   state_t              r_state;
   logic                r_kill_pend;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [63:0]         r_rip;
   logic [63:0]         r_op1;
   logic [63:0]         r_op2;
   logic [SIDE_W-1:0]   r_side;
   logic [63:0]         r_addr2;
   logic                r_src2_mem;
   logic                r_req_cyc;
   logic [63:0]         r_req_addr;
   logic [TAG_W-1:0]    r_req_tag;

   logic                w_resp_ack;
   logic                w_kill;
   logic                w_unused_tag;

   // Response handshake only for the index the current wait state expects
   assign w_resp_ack = dcRespcyc &&
                       (((r_state == S_WAIT1) && !dcResptag[0]) ||
                        ((r_state == S_WAIT2) &&  dcResptag[0]));

   // A kill seen in the completing cycle counts the same as an earlier one
   assign w_kill = killIn || r_kill_pend;

   // Upper response tag bits carry no information for this stage
   assign w_unused_tag = ^dcResptag[TAG_W-1:1];

   assign dcRespack = w_resp_ack;
   assign inReady   = r_in_ready;
   assign outValid  = r_out_valid;
   assign outRip    = r_rip;
   assign outOp1    = r_op1;
   assign outOp2    = r_op2;
   assign outSide   = r_side;
   assign dcReqcyc  = r_req_cyc;
   assign dcReq     = r_req_addr;
   assign dcReqtag  = r_req_tag;

   // Stage controller and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_kill_pend <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_rip       <= '0;
         r_op1       <= '0;
         r_op2       <= '0;
         r_side      <= '0;
         r_addr2     <= '0;
         r_src2_mem  <= 1'b0;
         r_req_cyc   <= 1'b0;
         r_req_addr  <= '0;
         r_req_tag   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_kill_pend <= 1'b0;
               if (inValid && !killIn) begin
                  r_rip      <= inRip;
                  r_op1      <= inOp1;
                  r_op2      <= inOp2;
                  r_side     <= inSide;
                  r_addr2    <= inAddrSrc2;
                  r_src2_mem <= inSrc2IsMem;
                  r_in_ready <= 1'b0;
                  if (inSrc1IsMem) begin
                     r_state    <= S_REQ1;
                     r_req_cyc  <= 1'b1;
                     r_req_addr <= inAddrSrc1;
                     r_req_tag  <= TAG_SRC1;
                  end else if (inSrc2IsMem) begin
                     r_state    <= S_REQ2;
                     r_req_cyc  <= 1'b1;
                     r_req_addr <= inAddrSrc2;
                     r_req_tag  <= TAG_SRC2;
                  end else begin
                     r_state     <= S_HOLD;
                     r_out_valid <= 1'b1;
                  end
               end
            end

            // Request stays up until accepted, even if killed meanwhile
            S_REQ1, S_REQ2: begin
               if (killIn) r_kill_pend <= 1'b1;
               if (dcReqack) begin
                  r_req_cyc <= 1'b0;
                  r_state   <= (r_state == S_REQ1) ? S_WAIT1 : S_WAIT2;
               end
            end

            S_WAIT1: begin
               if (w_resp_ack) begin
                  r_op1 <= dcResp;
                  if (w_kill) begin
                     r_state    <= S_IDLE;
                     r_in_ready <= 1'b1;
                  end else if (r_src2_mem) begin
                     r_state    <= S_REQ2;
                     r_req_cyc  <= 1'b1;
                     r_req_addr <= r_addr2;
                     r_req_tag  <= TAG_SRC2;
                  end else begin
                     r_state     <= S_HOLD;
                     r_out_valid <= 1'b1;
                  end
               end else if (killIn) begin
                  r_kill_pend <= 1'b1;
               end
            end

            S_WAIT2: begin
               if (w_resp_ack) begin
                  r_op2 <= dcResp;
                  if (w_kill) begin
                     r_state    <= S_IDLE;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state     <= S_HOLD;
                     r_out_valid <= 1'b1;
                  end
               end else if (killIn) begin
                  r_kill_pend <= 1'b1;
               end
            end

            S_HOLD: begin
               if (outReady || killIn) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_req_cyc   <= 1'b0;
            end
         endcase
      end
   end

endmodule
